// File: rtl/arm_prog_loader_if.sv
// -----------------------------------------------------------------------------
// arm_prog_loader_if
//
// Purpose: groups the byte-stream handshake, the arm_memory write port and the
// arm_core control/status lines of arm_prog_loader into one bundle.
//
// Signals:
//   in_data[7:0]      stream byte                    (source -> loader)
//   in_valid          in_data is valid               (source -> loader)
//   in_ready          loader accepts a byte          (loader -> source)
//   mem_addr[31:0]    byte address, arm_memory addr2 (loader -> memory)
//   mem_data_in[31:0] write data, arm_memory data_in2(loader -> memory)
//   mem_write_en      write strobe, arm_memory we[1] (loader -> memory)
//   core_rst          active-high reset of arm_core  (loader -> core)
//   halted            arm_core halted flag           (core   -> loader)
//   load_done         image written, core released   (loader -> system)
//   run_done          core halted after release      (loader -> system)
//   load_err          framing error, sticky          (loader -> system)
//
// Modports:
//   master : the environment (byte source, memory, core, status sink)
//   slave  : the loader itself
//
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both 1; while in_ready is 0 the source holds in_data/in_valid.
// -----------------------------------------------------------------------------
interface arm_prog_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_en;
    logic        core_rst;
    logic        halted;
    logic        load_done;
    logic        run_done;
    logic        load_err;

    modport master (
        output in_data, in_valid, halted,
        input  in_ready, mem_addr, mem_data_in, mem_write_en,
               core_rst, load_done, run_done, load_err
    );

    modport slave (
        input  in_data, in_valid, halted,
        output in_ready, mem_addr, mem_data_in, mem_write_en,
               core_rst, load_done, run_done, load_err
    );
endinterface

// File: rtl/arm_prog_loader.sv
// -----------------------------------------------------------------------------
// arm_prog_loader
//
// Purpose: receives a framed byte stream (4-byte little-endian word count N,
// then N little-endian data words), writes the words to arm_memory port 2
// starting at BASE_ADDR, holds arm_core in reset until the image is complete,
// then releases it and reports when the core halts.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bus          arm_prog_loader_if.slave (stream, memory write, core control)
//   dbg_state_o  current FSM state encoding, for debug/monitoring
//
// Parameters:
//   BASE_ADDR    byte address of the first image word
//   MAX_WORDS    largest accepted N; a larger header is a framing error
//
// Build option:
//   ARM_PROG_LOADER_CHECKSUM_EN  when defined, the frame carries a trailing
//   checksum word that must equal the mod-2^32 sum of all data words.
//
// All outputs are registered; in_ready is updated together with the state so
// that it always reflects whether the current state consumes bytes.
// -----------------------------------------------------------------------------
module arm_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    arm_prog_loader_if.slave   bus,
    output logic [2:0]         dbg_state_o
);

`ifdef ARM_PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_WR   = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5,
        S_CSUM = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_WR   = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;
`endif

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [31:0] n_q;
    logic [31:0] word_cnt_q;
    logic        in_ready_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_in_q;
    logic        mem_write_en_q;
    logic        core_rst_q;
    logic        load_done_q;
    logic        run_done_q;
    logic        load_err_q;
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    logic        byte_fire;
    logic        last_byte;
    logic [31:0] word_d;
    logic [31:0] word_cnt_d;

    // word_d is the word under assembly with the incoming byte merged in;
    // on the 4th byte it is the complete little-endian word.
    always_comb begin
        byte_fire  = bus.in_valid & in_ready_q;
        last_byte  = byte_fire && (byte_cnt_q == 2'd3);
        word_d     = word_q;
        word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
        word_cnt_d = word_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_HDR;
            byte_cnt_q     <= 2'd0;
            word_q         <= 32'd0;
            n_q            <= 32'd0;
            word_cnt_q     <= 32'd0;
            in_ready_q     <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_data_in_q  <= 32'd0;
            mem_write_en_q <= 1'b0;
            core_rst_q     <= 1'b1;
            load_done_q    <= 1'b0;
            run_done_q     <= 1'b0;
            load_err_q     <= 1'b0;
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
            sum_q          <= 32'd0;
`endif
        end else begin
            // Byte assembly is shared by every byte-consuming state; the
            // counter wraps to 0 on the 4th byte, ready for the next word.
            if (byte_fire) begin
                word_q     <= word_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            case (state_q)
                S_HDR: begin
                    in_ready_q <= 1'b1;
                    if (last_byte) begin
                        n_q <= word_d;
                        if (word_d == 32'd0) begin
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            state_q     <= S_RUN;
                            in_ready_q  <= 1'b0;
                            core_rst_q  <= 1'b0;
                            load_done_q <= 1'b1;
`endif
                        end else if (word_d > MAX_WORDS) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (last_byte) begin
                        mem_data_in_q  <= word_d;
                        mem_write_en_q <= 1'b1;
                        in_ready_q     <= 1'b0;
                        state_q        <= S_WR;
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
                        sum_q          <= sum_q + word_d;
`endif
                    end
                end

                // mem_addr already equals BASE_ADDR + 4*word_cnt here; it
                // advances together with the word counter as the strobe drops.
                S_WR: begin
                    mem_write_en_q <= 1'b0;
                    word_cnt_q     <= word_cnt_d;
                    mem_addr_q     <= mem_addr_q + 32'd4;
                    if (word_cnt_d == n_q) begin
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
                        state_q    <= S_CSUM;
                        in_ready_q <= 1'b1;
`else
                        state_q     <= S_RUN;
                        core_rst_q  <= 1'b0;
                        load_done_q <= 1'b1;
`endif
                    end else begin
                        state_q    <= S_DATA;
                        in_ready_q <= 1'b1;
                    end
                end

`ifdef ARM_PROG_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (last_byte) begin
                        in_ready_q <= 1'b0;
                        if (word_d == sum_q) begin
                            state_q     <= S_RUN;
                            core_rst_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif

                // halted is only looked at here, so a core that flags halted
                // while still held in reset cannot end the run early.
                S_RUN: begin
                    if (bus.halted) begin
                        run_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end

                S_DONE: begin
                end

                S_ERR: begin
                end

                default: begin
                    state_q    <= S_ERR;
                    in_ready_q <= 1'b0;
                    core_rst_q <= 1'b1;
                    load_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_data_in_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign bus.core_rst     = core_rst_q;
    assign bus.load_done    = load_done_q;
    assign bus.run_done     = run_done_q;
    assign bus.load_err     = load_err_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_arm_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_arm_prog_loader
//
// Drives framed images into arm_prog_loader and compares memory writes and
// status against a frame-level reference model: the image is a list of words,
// word i is expected at BASE + 4*i, and the outcome (run or error) follows
// from the header value and, when enabled, the checksum.
// -----------------------------------------------------------------------------
module tb_arm_prog_loader;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int unsigned MAX_WORDS = 1024;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arm_prog_loader_if bus ();

    arm_prog_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks;
    int n_errors;

    logic [63:0] exp_q[$];      // {addr, data} of each expected write
    logic [7:0]  tx_q[$];       // bytes of the frame to send
    logic [31:0] img_q[$];      // image words (reference model input)

    int  cyc;
    int  wr_count;
    int  wr_cyc;
    int  rel_cyc;
    bit  prev_core_rst;

    // Write monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic [63:0] exp;
        #1;
        cyc = cyc + 1;
        if (bus.mem_write_en === 1'b1) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus.mem_addr, bus.mem_data_in);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_data_in} !== exp) begin
                    n_errors = n_errors + 1;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_data_in, exp[63:32], exp[31:0]);
                end
            end
            n_checks = n_checks + 1;
            if (bus.in_ready !== 1'b0) begin
                n_errors = n_errors + 1;
                $display("FAIL ready_during_write: got in_ready=%b, required 0", bus.in_ready);
            end
            wr_count = wr_count + 1;
            wr_cyc   = cyc;
        end
        if (prev_core_rst && (bus.core_rst === 1'b0)) rel_cyc = cyc;
        prev_core_rst = (bus.core_rst === 1'b1);
    end

    // ---------------- reference model ----------------
    // Builds the byte frame for header hdr over img_q and records the writes
    // the loader must make. csum_adj perturbs the checksum word.
    task automatic build_frame(input logic [31:0] hdr, input logic [31:0] csum_adj);
        logic [31:0] sum;
        logic [31:0] w;
        tx_q.delete();
        sum = 32'd0;
        for (int b = 0; b < 4; b++) tx_q.push_back(8'((hdr >> (8 * b)) & 32'hFF));
        for (int i = 0; i < img_q.size(); i++) begin
            w   = img_q[i];
            sum = sum + w;
            for (int b = 0; b < 4; b++) tx_q.push_back(8'((w >> (8 * b)) & 32'hFF));
            if (hdr <= MAX_WORDS) exp_q.push_back({BASE + 32'(4 * i), w});
        end
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
        if (hdr <= MAX_WORDS) begin
            w = sum + csum_adj;
            for (int b = 0; b < 4; b++) tx_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
`else
        if (csum_adj != 32'd0) sum = 32'd0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.halted   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        wr_count = 0;
        wr_cyc   = -1;
        rel_cyc  = -1;
        @(negedge clk);
    endtask

    // Offers one byte (after optional random idle cycles) and holds it until
    // the handshake edge or until the budget runs out.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input int budget,
                             output bit ok);
        ok = 1'b0;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int count);
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < count && i < tx_q.size(); i++) begin
            send_byte(tx_q[i], gap_pct, 20, ok);
            if (!ok) all_ok = 1'b0;
        end
        n_checks = n_checks + 1;
        if (!all_ok) begin
            n_errors = n_errors + 1;
            $display("FAIL byte_accept: got a byte refused for 20 cycles, required all accepted");
        end
    endtask

    task automatic wait_status(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.load_done === 1'b1 || bus.load_err === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks = n_checks + 1;
        if (!seen) begin
            n_errors = n_errors + 1;
            $display("FAIL status_timeout: got no load_done/load_err in %0d cycles, required one", budget);
        end
    endtask

    task automatic check_run_state(input string name, input int words);
        n_checks = n_checks + 1;
        if (bus.load_done !== 1'b1 || bus.core_rst !== 1'b0 || bus.load_err !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL %s_released: got load_done=%b core_rst=%b load_err=%b, required 1 0 0",
                     name, bus.load_done, bus.core_rst, bus.load_err);
        end
        n_checks = n_checks + 1;
        if (wr_count != words || exp_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d",
                     name, wr_count, exp_q.size(), words);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if (bus.in_ready !== 1'b0 || bus.mem_write_en !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_hs: got in_ready=%b we=%b, required 0 0", bus.in_ready, bus.mem_write_en);
        end
        n_checks = n_checks + 1;
        if (bus.mem_addr !== BASE || bus.mem_data_in !== 32'd0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_mem: got addr=%h data=%h, required %h 0", bus.mem_addr, bus.mem_data_in, BASE);
        end
        n_checks = n_checks + 1;
        if (bus.core_rst !== 1'b1 || bus.load_done !== 1'b0 || bus.run_done !== 1'b0 || bus.load_err !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_status: got core_rst=%b load_done=%b run_done=%b load_err=%b, required 1 0 0 0",
                     bus.core_rst, bus.load_done, bus.run_done, bus.load_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks = n_checks + 1;
        if (bus.in_ready !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_ready: got in_ready=%b after release, required 1", bus.in_ready);
        end
    endtask

    task automatic test_normal();
        reset_dut();
        img_q = '{32'hE3A0_0001, 32'hE280_0002};
        build_frame(32'd2, 32'd0);
`ifndef ARM_PROG_LOADER_CHECKSUM_EN
        n_checks = n_checks + 1;
        if (tx_q != '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                      8'h02, 8'h00, 8'h80, 8'hE2}) begin
            n_errors = n_errors + 1;
            $display("FAIL frame_bytes: model byte order differs from the reference frame");
        end
        send_frame(0, tx_q.size());
        // last byte consumed on the previous edge: the write must be visible now
        n_checks = n_checks + 1;
        if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== BASE + 32'd4) begin
            n_errors = n_errors + 1;
            $display("FAIL write_latency: got we=%b addr=%h, required 1 %h",
                     bus.mem_write_en, bus.mem_addr, BASE + 32'd4);
        end
`else
        send_frame(0, tx_q.size());
`endif
        wait_status(40);
        check_run_state("normal", 2);
`ifndef ARM_PROG_LOADER_CHECKSUM_EN
        n_checks = n_checks + 1;
        if (rel_cyc != wr_cyc + 1) begin
            n_errors = n_errors + 1;
            $display("FAIL release_latency: got core_rst fall %0d cycles after last write, required 1",
                     rel_cyc - wr_cyc);
        end
`endif
        repeat (9) @(negedge clk);
        n_checks = n_checks + 1;
        if (bus.run_done !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL run_done_early: got %b, required 0", bus.run_done);
        end
        bus.halted = 1'b1;
        @(negedge clk);
        bus.halted = 1'b0;
        n_checks = n_checks + 1;
        if (bus.run_done !== 1'b1 || bus.core_rst !== 1'b0 || bus.load_done !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL run_done: got run_done=%b core_rst=%b load_done=%b, required 1 0 1",
                     bus.run_done, bus.core_rst, bus.load_done);
        end
        repeat (3) @(negedge clk);
        n_checks = n_checks + 1;
        if (bus.run_done !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL done_hold: got run_done=%b in_ready=%b, required 1 0", bus.run_done, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        img_q = '{32'hE3A0_0001, 32'hE280_0002};
        build_frame(32'd2, 32'd0);
        send_frame(60, tx_q.size());
        wait_status(40);
        check_run_state("gaps", 2);
        for (int k = 0; k < 3; k++) begin
            int n;
            reset_dut();
            n = $urandom_range(1, 6);
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            build_frame(32'(n), 32'd0);
            send_frame($urandom_range(0, 70), tx_q.size());
            wait_status(40);
            check_run_state("random", n);
        end
    endtask

    task automatic test_max_words();
        reset_dut();
        img_q.delete();
        for (int i = 0; i < MAX_WORDS; i++) img_q.push_back($urandom);
        build_frame(32'(MAX_WORDS), 32'd0);
        send_frame(0, tx_q.size());
        wait_status(40);
        check_run_state("max", MAX_WORDS);
    endtask

    task automatic test_oversize();
        bit ok;
        reset_dut();
        img_q.delete();
        build_frame(32'(MAX_WORDS + 1), 32'd0);
        send_frame(0, 4);
        n_checks = n_checks + 1;
        if (bus.load_err !== 1'b1 || bus.core_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL oversize_err: got load_err=%b core_rst=%b in_ready=%b, required 1 1 0",
                     bus.load_err, bus.core_rst, bus.in_ready);
        end
        send_byte(8'hA5, 0, 10, ok);
        n_checks = n_checks + 1;
        if (ok !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL oversize_accept: got extra byte accepted, required refused");
        end
        bus.halted = 1'b1;
        repeat (2) @(negedge clk);
        bus.halted = 1'b0;
        n_checks = n_checks + 1;
        if (bus.run_done !== 1'b0 || bus.load_done !== 1'b0 || bus.core_rst !== 1'b1 || wr_count != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL oversize_hold: got run_done=%b load_done=%b core_rst=%b writes=%0d, required 0 0 1 0",
                     bus.run_done, bus.load_done, bus.core_rst, wr_count);
        end
    endtask

    task automatic test_empty();
        reset_dut();
        img_q.delete();
        build_frame(32'd0, 32'd0);
        send_frame(0, tx_q.size());
        // final byte consumed on the previous edge: released now
        check_run_state("empty", 0);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        img_q = '{32'hE3A0_0001, 32'hE280_0002};
        build_frame(32'd2, 32'd0);
        send_frame(0, 6);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if (bus.in_ready !== 1'b0 || bus.core_rst !== 1'b1 || bus.mem_addr !== BASE ||
            bus.mem_data_in !== 32'd0 || bus.load_done !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL midreset: got in_ready=%b core_rst=%b addr=%h data=%h load_done=%b, required 0 1 %h 0 0",
                     bus.in_ready, bus.core_rst, bus.mem_addr, bus.mem_data_in, bus.load_done, BASE);
        end
        n_checks = n_checks + 1;
        if (wr_count != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL midreset_writes: got %0d writes, required 0", wr_count);
        end
        reset_dut();
        build_frame(32'd2, 32'd0);
        send_frame(0, tx_q.size());
        wait_status(40);
        check_run_state("reload", 2);
    endtask

`ifdef ARM_PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        reset_dut();
        img_q = '{32'h0000_0010};
        build_frame(32'd1, 32'd0);
        send_frame(0, tx_q.size());
        check_run_state("csum_ok", 1);
        reset_dut();
        build_frame(32'd1, 32'd1);
        send_frame(0, tx_q.size());
        n_checks = n_checks + 1;
        if (bus.load_err !== 1'b1 || bus.core_rst !== 1'b1 || bus.load_done !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL csum_bad: got load_err=%b core_rst=%b load_done=%b, required 1 1 0",
                     bus.load_err, bus.core_rst, bus.load_done);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        wr_count      = 0;
        wr_cyc        = -1;
        rel_cyc       = -1;
        prev_core_rst = 1'b1;
        rst           = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.halted    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        test_reset();
        test_normal();
        test_backpressure();
        test_oversize();
        test_empty();
        test_reset_mid();
        test_max_words();
`ifdef ARM_PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arm_prog_loader.md
Name: arm_prog_loader

Overview:
- Hardware program loader that sits upstream of arm_memory and arm_core; it takes over the file-loading job of the simulation bench so the same flow works on silicon.
- Accepts a framed byte stream from a byte source (UART receiver or bench driver) over a valid/ready handshake.
- Assembles bytes into 32-bit words and writes them into arm_memory data port 2.
- Holds arm_core in reset until the full image is written, releases it, then reports when the core halts.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first image word.
- MAX_WORDS, 1024, maximum image length in words; larger headers are rejected.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  32  byte address to arm_memory addr2.
- mem_data_in  output  32  write data to arm_memory data_in2.
- mem_write_en  output  1  write strobe to arm_memory we[1].
- core_rst  output  1  active-high reset to arm_core.
- halted  input  1  arm_core halted flag.
- load_done  output  1  image fully written and core released.
- run_done  output  1  core has halted after release (sticky).
- load_err  output  1  framing error (sticky until reset).

Behaviour:
- A byte transfers on a rising edge where in_valid and in_ready are both 1. Bytes are little-endian within a word: byte 0 goes to bits [7:0].
- Frame: 4-byte header N (word count), then N data words. The CHECKSUM variant appends one extra word (see Optional Feature).
- Reset (rst=0, asynchronous) puts outputs in these states:
  - in_ready=0, mem_write_en=0, mem_addr=BASE_ADDR, mem_data_in=0.
  - core_rst=1, load_done=0, run_done=0, load_err=0.
  - Byte counter=0, word counter=0, state=HDR.
- States:
  - HDR: in_ready=1; collect 4 bytes into N.
    - On the 4th byte: N==0 goes to RUN; N>MAX_WORDS goes to ERR; otherwise goes to DATA.
  - DATA: in_ready=1; collect 4 bytes; on the 4th byte latch the word into mem_data_in and go to WR.
  - WR: in_ready=0, mem_write_en=1 for exactly one cycle, mem_addr = BASE_ADDR + 4*word_count.
    - Next cycle: word_count+1; mem_write_en=0.
    - If word_count+1==N, go to RUN (or CSUM when the option is enabled); else go to DATA.
  - RUN: core_rst=0, load_done=1, in_ready=0. When halted=1 is sampled, set run_done=1 and go to DONE.
  - DONE: terminal; core_rst stays 0; outputs hold.
  - ERR: terminal; load_err=1, core_rst=1, in_ready=0.
- Exactly one memory write per data word. Write latency from the last byte's handshake to mem_write_en=1 is 1 cycle.
- Throughput: at most 1 word per 5 cycles (4 byte cycles plus 1 WR cycle).
- mem_addr wraps modulo 2^32. Wrap cannot occur when BASE_ADDR + 4*MAX_WORDS fits in 32 bits.
- in_valid while in_ready=0: the byte is not consumed; the source must hold it.
- Bytes arriving after RUN/DONE/ERR are never consumed.
- halted is ignored in every state except RUN. This covers an arm_core that reports halted while held in reset.
- Reset mid-load aborts the load immediately. Memory contents already written are not cleared; the next frame overwrites them.

Optional Feature:
- Macro: ARM_PROG_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, state CSUM accepts 4 more bytes as checksum C.
  - The loader keeps a running sum S of all data words, mod 2^32, with S=0 at reset; the header is excluded.
  - C==S goes to RUN; otherwise goes to ERR with core_rst held at 1.
  - For N==0, HDR goes to CSUM and expects C=0.
- When undefined: no CSUM state and no sum register; the last WR goes directly to RUN.

Test Plan:
- Normal load: N=2, words 32'hE3A00001, 32'hE2800002 (bytes 02 00 00 00 01 00 A0 E3 02 00 80 E2), halted pulsed 10 cycles after release.
  - Required: writes addr 0 then 4 with those data; each mem_write_en is exactly 1 cycle; core_rst falls 1 cycle after the second write.
  - Required: load_done=1; run_done=1 one cycle after halted is sampled.
- Backpressure and gaps: same frame with in_valid toggled randomly.
  - Required: identical writes; no byte is consumed during a WR cycle.
- Oversize: header N=MAX_WORDS+1.
  - Required: load_err=1 after the 4th byte; no writes; core_rst stays 1; later bytes are not accepted.
- Empty image: N=0.
  - Required: no writes; core_rst=0 and load_done=1 one cycle after the header completes (option off).
- Reset mid-load: assert rst=0 after 6 bytes of the normal frame, then resend the full frame.
  - Required: all outputs return to reset values asynchronously; second load writes addr 0 and 4 correctly.
- Checksum (option on): N=1, word 32'h0000_0010, C=32'h10 gives RUN; C=32'h11 gives load_err=1 with core_rst held at 1.
